// File: rtl/wb_regfile.sv
// wb_regfile: architectural register file and write-back sink.
// Two combinational read ports with write bypass, plus a pending scoreboard.
module wb_regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wb_we,
  input  logic [ADDR_W-1:0]   wb_waddr,
  input  logic [DATA_W-1:0]   wb_wdata,
  input  logic                re1,
  input  logic [ADDR_W-1:0]   raddr1,
  output logic [DATA_W-1:0]   rdata1,
  output logic                busy1,
  input  logic                re2,
  input  logic [ADDR_W-1:0]   raddr2,
  output logic [DATA_W-1:0]   rdata2,
  output logic                busy2,
  input  logic                iss_valid,
  input  logic [ADDR_W-1:0]   iss_addr,
  output logic [NUM_REGS-1:0] pending
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;

  logic wb_nz;
  logic hit1;
  logic hit2;

  assign wb_nz   = wb_we && (wb_waddr != '0);
  assign hit1    = wb_we && (wb_waddr == raddr1);
  assign hit2    = wb_we && (wb_waddr == raddr2);
  assign pending = pending_q;

  // Next register contents: reset clears, r0 never holds data.
  always_comb begin
    regs_d = regs_q;
    if (wb_nz) begin
      regs_d[wb_waddr] = wb_wdata;
    end
    regs_d[0] = '0;
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_d[i] = '0;
      end
    end
  end

  // Scoreboard: a new issue wins over a same-cycle retire.
  always_comb begin
    pending_d = pending_q;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (iss_valid && (iss_addr == ADDR_W'(i))) begin
        pending_d[i] = 1'b1;
      end else if (wb_we && (wb_waddr == ADDR_W'(i))) begin
        pending_d[i] = 1'b0;
      end
    end
    pending_d[0] = 1'b0;
    if (rst) begin
      pending_d = '0;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    regs_q    <= regs_d;
    pending_q <= pending_d;
  end

  // Read port 1 with write-back bypass.
  always_comb begin
    rdata1 = '0;
    busy1  = 1'b0;
    if (!rst && re1 && (raddr1 != '0)) begin
      rdata1 = hit1 ? wb_wdata : regs_q[raddr1];
      busy1  = pending_q[raddr1] && !hit1;
    end
  end

  // Read port 2 with write-back bypass.
  always_comb begin
    rdata2 = '0;
    busy2  = 1'b0;
    if (!rst && re2 && (raddr2 != '0)) begin
      rdata2 = hit2 ? wb_wdata : regs_q[raddr2];
      busy2  = pending_q[raddr2] && !hit2;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed scenarios plus randomized traffic
// checked against an array-based model of the register file.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        re1, re2;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2;
  logic        busy1, busy2;
  logic        iss_valid;
  logic [4:0]  iss_addr;
  logic [31:0] pending;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_pend;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1), .busy1(busy1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2), .busy2(busy2),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .pending(pending)
  );

  function automatic void model_edge();
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_pend = '0;
    end else begin
      if (wb_we && wb_waddr != 0) m_regs[wb_waddr] = wb_wdata;
      if (wb_we) m_pend[wb_waddr] = 1'b0;
      if (iss_valid && iss_addr != 0) m_pend[iss_addr] = 1'b1;
      m_pend[0] = 1'b0;
    end
  endfunction

  function automatic logic [31:0] exp_rd(logic re, logic [4:0] a);
    if (rst || !re) return '0;
    if (a == 0) return '0;
    if (wb_we && wb_waddr == a) return wb_wdata;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(logic re, logic [4:0] a);
    if (rst || !re || a == 0) return 1'b0;
    if (wb_we && wb_waddr == a) return 1'b0;
    return m_pend[a];
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    rst = 0; wb_we = 0; wb_waddr = 0; wb_wdata = 0;
    re1 = 0; raddr1 = 0; re2 = 0; raddr2 = 0;
    iss_valid = 0; iss_addr = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1; wb_we = 1; wb_waddr = 5; wb_wdata = 32'hDEADBEEF;
    re1 = 1; raddr1 = 5;
    tick();
    tick();
    checks++;
    if (rdata1 !== 32'h0) begin
      errors++;
      $display("FAIL rst_hold_rdata got %h exp 0", rdata1);
    end
    rst = 0; wb_we = 0;
    #1;
    checks++;
    if (rdata1 !== 32'h0) begin
      errors++;
      $display("FAIL reset_r5 got %h exp 0", rdata1);
    end
    checks++;
    if (pending !== 32'h0) begin
      errors++;
      $display("FAIL reset_pending got %h exp 0", pending);
    end
  endtask

  task automatic test_write_read();
    idle();
    wb_we = 1; wb_waddr = 3; wb_wdata = 32'h12345678;
    tick();
    wb_we = 0; re1 = 1; raddr1 = 3;
    #1;
    checks++;
    if (rdata1 !== 32'h12345678) begin
      errors++;
      $display("FAIL read_r3 got %h exp 12345678", rdata1);
    end
    re1 = 0;
    #1;
    checks++;
    if (rdata1 !== 32'h0) begin
      errors++;
      $display("FAIL read_disabled got %h exp 0", rdata1);
    end
  endtask

  task automatic test_r0_bypass();
    idle();
    wb_we = 1; wb_waddr = 0; wb_wdata = 32'hFFFFFFFF;
    re1 = 1; raddr1 = 0;
    #1;
    checks++;
    if (rdata1 !== 32'h0) begin
      errors++;
      $display("FAIL r0_bypass got %h exp 0", rdata1);
    end
    tick();
    wb_we = 0;
    #1;
    checks++;
    if (rdata1 !== 32'h0) begin
      errors++;
      $display("FAIL r0_read got %h exp 0", rdata1);
    end
    wb_we = 1; wb_waddr = 7; wb_wdata = 32'hA5A5A5A5;
    re1 = 1; raddr1 = 7; re2 = 1; raddr2 = 7;
    #1;
    checks++;
    if (rdata1 !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL bypass_p1 got %h exp a5a5a5a5", rdata1);
    end
    checks++;
    if (rdata2 !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL bypass_p2 got %h exp a5a5a5a5", rdata2);
    end
    tick();
    wb_we = 0;
    #1;
    checks++;
    if (rdata2 !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL r7_after got %h exp a5a5a5a5", rdata2);
    end
  endtask

  task automatic test_scoreboard();
    idle();
    iss_valid = 1; iss_addr = 9;
    tick();
    iss_valid = 0; re1 = 1; raddr1 = 9;
    #1;
    checks++;
    if (busy1 !== 1'b1 || pending[9] !== 1'b1) begin
      errors++;
      $display("FAIL sb_busy got %b/%b exp 1/1", busy1, pending[9]);
    end
    tick();
    checks++;
    if (busy1 !== 1'b1) begin
      errors++;
      $display("FAIL sb_busy_hold got %b exp 1", busy1);
    end
    wb_we = 1; wb_waddr = 9; wb_wdata = 32'hCAFE0009;
    #1;
    checks++;
    if (busy1 !== 1'b0 || rdata1 !== 32'hCAFE0009) begin
      errors++;
      $display("FAIL sb_wb got %b/%h exp 0/cafe0009", busy1, rdata1);
    end
    tick();
    wb_we = 0;
    #1;
    checks++;
    if (pending[9] !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL sb_clear got %b/%b exp 0/0", pending[9], busy1);
    end
    iss_valid = 1; iss_addr = 0;
    tick();
    iss_valid = 0;
    checks++;
    if (pending !== 32'h0) begin
      errors++;
      $display("FAIL sb_r0 got %h exp 0", pending);
    end
  endtask

  task automatic test_set_clear();
    idle();
    iss_valid = 1; iss_addr = 4;
    tick();
    wb_we = 1; wb_waddr = 4; wb_wdata = 32'h44440004;
    tick();
    idle();
    re2 = 1; raddr2 = 4;
    #1;
    checks++;
    if (pending[4] !== 1'b1 || busy2 !== 1'b1) begin
      errors++;
      $display("FAIL setclr_pend got %b/%b exp 1/1", pending[4], busy2);
    end
    checks++;
    if (rdata2 !== 32'h44440004) begin
      errors++;
      $display("FAIL setclr_data got %h exp 44440004", rdata2);
    end
  endtask

  task automatic test_reset_midflight();
    idle();
    iss_valid = 1; iss_addr = 9;
    tick();
    iss_addr = 12;
    tick();
    iss_valid = 0;
    checks++;
    if (pending !== 32'h1210) begin
      errors++;
      $display("FAIL mid_pre got %h exp 00001210", pending);
    end
    rst = 1; wb_we = 1; wb_waddr = 12; wb_wdata = 32'h12121212;
    re1 = 1; raddr1 = 12; re2 = 1; raddr2 = 9;
    #1;
    checks++;
    if (rdata1 !== 0 || busy1 !== 0 || busy2 !== 0) begin
      errors++;
      $display("FAIL mid_rst got %h/%b/%b exp 0/0/0", rdata1, busy1, busy2);
    end
    tick();
    rst = 0; wb_we = 0; raddr2 = 3;
    #1;
    checks++;
    if (pending !== 32'h0 || rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
      errors++;
      $display("FAIL mid_post got %h/%h/%h exp 0/0/0", pending, rdata1, rdata2);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst       = ($urandom_range(0, 49) == 0);
      wb_we     = $urandom_range(0, 1);
      wb_waddr  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      wb_wdata  = $urandom;
      re1       = ($urandom_range(0, 7) != 0);
      raddr1    = 5'($urandom_range(0, 7));
      re2       = ($urandom_range(0, 7) != 0);
      raddr2    = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      iss_valid = $urandom_range(0, 1);
      iss_addr  = 5'($urandom_range(0, 7));
      #1;
      checks++;
      if (rdata1 !== exp_rd(re1, raddr1) || busy1 !== exp_busy(re1, raddr1)) begin
        errors++;
        $display("FAIL rand_p1 n=%0d got %h/%b exp %h/%b", n, rdata1, busy1,
                 exp_rd(re1, raddr1), exp_busy(re1, raddr1));
      end
      checks++;
      if (rdata2 !== exp_rd(re2, raddr2) || busy2 !== exp_busy(re2, raddr2)) begin
        errors++;
        $display("FAIL rand_p2 n=%0d got %h/%b exp %h/%b", n, rdata2, busy2,
                 exp_rd(re2, raddr2), exp_busy(re2, raddr2));
      end
      checks++;
      if (pending !== m_pend) begin
        errors++;
        $display("FAIL rand_pend n=%0d got %h exp %h", n, pending, m_pend);
      end
      tick();
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_write_read();
    test_r0_bypass();
    test_scoreboard();
    test_set_clear();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- General-purpose register file and the write-back sink for the EX→MEM→WB result path: accepts the (write enable, address, data) triple produced at the end of the pipeline.
- Provides two combinational read ports to ID, with same-cycle write-to-read bypass.
- Contains a per-register pending scoreboard: ID sets a bit when it issues a long-latency producer (load); write-back clears it. ID uses the busy flags to stall.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register address width
NUM_REGS, 32, number of architectural registers (2**ADDR_W)

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  reset, synchronous, active-high
wb_we  input  1  write-back enable
wb_waddr  input  ADDR_W  write-back destination register
wb_wdata  input  DATA_W  write-back data
re1  input  1  read port 1 enable
raddr1  input  ADDR_W  read port 1 address
rdata1  output  DATA_W  read port 1 data
busy1  output  1  register at raddr1 has an outstanding producer
re2  input  1  read port 2 enable
raddr2  input  ADDR_W  read port 2 address
rdata2  output  DATA_W  read port 2 data
busy2  output  1  register at raddr2 has an outstanding producer
iss_valid  input  1  ID issues a long-latency producer this cycle
iss_addr  input  ADDR_W  destination of that producer
pending  output  NUM_REGS  raw scoreboard vector, for debug and hazard logic

Behaviour:
- Reset (rst=1 at posedge):
  - all NUM_REGS registers cleared to 0;
  - pending cleared to 0;
  - wb_we and iss_valid in that cycle are ignored.
- While rst is held:
  - rdata1/2 = 0;
  - busy1/2 = 0.
- Write: at posedge with wb_we=1 and wb_waddr≠0, regs[wb_waddr] ← wb_wdata. Writes to r0 are discarded.
- r0: always reads 0 and is never pending.
- Read ports are combinational, zero latency. Evaluate each port independently, with this priority:
  1. rst=1 or re=0 → 0.
  2. raddr=0 → 0.
  3. wb_we=1 and wb_waddr=raddr → wb_wdata (bypass).
  4. Otherwise → regs[raddr].
- Both ports may read the same address. Bypass applies to each port independently.
- Scoreboard update, at each posedge (not in reset), for every register i≠0:
  - set = iss_valid and iss_addr=i;
  - clr = wb_we and wb_waddr=i;
  - pending[i] ← set ? 1 : (clr ? 0 : pending[i]).
  - Set wins on a simultaneous set and clear: a new producer is issued while the old one retires.
  - iss_valid with iss_addr=0 has no effect.
  - pending[0] is constant 0.
- busy flags:
  - busyN = reN and raddrN≠0 and pending[raddrN] and not (wb_we and wb_waddr=raddrN).
  - A register whose producer is writing back this cycle is not busy, because bypass supplies its data.
  - busyN is 0 when reN=0 or rst=1.
- Write-back to a non-pending register is legal: data is written and the scoreboard is unchanged.
- ID guarantees at most one outstanding producer per register. A second iss_valid to an already-pending register leaves it pending.
- Reset mid-operation (pending bits set, write in flight): the reset cycle wins. All state is 0 after the edge, and the in-flight write is lost.
- No other latency: a write at edge N is visible from regs after edge N, and via bypass during the cycle before edge N.

Test Plan:
- Reset: drive rst=1 for 2 cycles with wb_we=1, wb_waddr=5, wb_wdata=0xDEADBEEF → after release, rdata1 for raddr1=5 reads 0; pending=0.
- Write/read: write r3=0x12345678 at edge N → from cycle N+1, re1=1/raddr1=3 gives 0x12345678; re1=0 gives 0.
- r0 and bypass:
  - write r0=0xFFFFFFFF → raddr1=0 reads 0.
  - Same cycle, wb_we=1, wb_waddr=7, wb_wdata=0xA5A5A5A5 with raddr1=raddr2=7 → both rdata read 0xA5A5A5A5 before the edge.
- Scoreboard: iss_valid, iss_addr=9 at edge N → busy1=1 for raddr1=9 on following cycles; in the write-back cycle (wb_we, wb_waddr=9) busy1=0 and rdata1=wb_wdata; pending[9]=0 after the edge.
- Simultaneous set/clear: pending[4]=1, then in one cycle iss_valid with iss_addr=4 and wb_we with wb_waddr=4 → pending[4]=1 after the edge, and regs[4] holds the written data.
- Reset mid-flight: pending[9]=1 and pending[12]=1, assert rst together with wb_we to r12 → all pending=0, r12=0 afterwards.
